// File: rtl/axi2mem_tcdm_rdwr_arb.sv
// Shares one TCDM initiator port between the axi2mem read and write channels.
// Arbitration is round-robin with lock-on-stall, and an in-order owner queue
// steers each response valid back to the channel that issued the request.
// Optional macro AXI2MEM_TCDM_ARB_ERR_EN adds a sticky protocol error flag err_o.
module axi2mem_tcdm_rdwr_arb #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    rd_req_i,
  input  logic [ADDR_WIDTH-1:0]   rd_add_i,
  input  logic                    rd_we_i,
  input  logic [DATA_WIDTH-1:0]   rd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] rd_be_i,
  output logic                    rd_gnt_o,
  output logic [DATA_WIDTH-1:0]   rd_r_rdata_o,
  output logic                    rd_r_valid_o,
  input  logic                    wr_req_i,
  input  logic [ADDR_WIDTH-1:0]   wr_add_i,
  input  logic                    wr_we_i,
  input  logic [DATA_WIDTH-1:0]   wr_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wr_be_i,
  output logic                    wr_gnt_o,
  output logic [DATA_WIDTH-1:0]   wr_r_rdata_o,
  output logic                    wr_r_valid_o,
  output logic                    tcdm_req_o,
  output logic [ADDR_WIDTH-1:0]   tcdm_add_o,
  output logic                    tcdm_we_o,
  output logic [DATA_WIDTH-1:0]   tcdm_wdata_o,
  output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
  input  logic                    tcdm_gnt_i,
  input  logic [DATA_WIDTH-1:0]   tcdm_r_rdata_i,
  input  logic                    tcdm_r_valid_i
`ifdef AXI2MEM_TCDM_ARB_ERR_EN
  ,
  output logic                    err_o
`endif
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  // A single-entry queue still gets a 1-bit pointer; the count caps occupancy.
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  // Channel encoding shared by rr_ptr, lock_owner and queue entries: 0=RD, 1=WR.
  logic               rr_ptr;
  logic               lock;
  logic               lock_owner;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [2**PTR_W-1:0] owner_q;

  logic sel_valid;
  logic sel_wr;
  logic owner_req;
  logic lock_dropped;
  logic full;
  logic push;
  logic pop;
  logic head;

  always_comb begin
    owner_req    = lock_owner ? wr_req_i : rd_req_i;
    lock_dropped = lock && !owner_req;
    sel_valid    = rd_req_i || wr_req_i;
    if (lock && owner_req)          sel_wr = lock_owner;
    else if (rd_req_i && wr_req_i)  sel_wr = rr_ptr;
    else                            sel_wr = wr_req_i;
  end

  // A response in the same cycle frees a slot, so a full queue may still issue.
  assign full       = (count == CNT_W'(MAX_OUTSTANDING));
  assign tcdm_req_o = sel_valid && (!full || tcdm_r_valid_i);
  assign push       = tcdm_req_o && tcdm_gnt_i;
  assign rd_gnt_o   = push && !sel_wr;
  assign wr_gnt_o   = push && sel_wr;

  assign tcdm_add_o   = !sel_valid ? '0   : (sel_wr ? wr_add_i   : rd_add_i);
  assign tcdm_we_o    = !sel_valid ? 1'b0 : (sel_wr ? wr_we_i    : rd_we_i);
  assign tcdm_wdata_o = !sel_valid ? '0   : (sel_wr ? wr_wdata_i : rd_wdata_i);
  assign tcdm_be_o    = !sel_valid ? '0   : (sel_wr ? wr_be_i    : rd_be_i);

  // Responses with nothing outstanding are dropped rather than popped.
  assign pop          = tcdm_r_valid_i && (count != '0);
  assign head         = owner_q[rd_ptr];
  assign rd_r_valid_o = pop && !head;
  assign wr_r_valid_o = pop && head;
  assign rd_r_rdata_o = tcdm_r_rdata_i;
  assign wr_r_rdata_o = tcdm_r_rdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr     <= 1'b0;
      lock       <= 1'b0;
      lock_owner <= 1'b0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      owner_q    <= '0;
    end else begin
      if (push) begin
        owner_q[wr_ptr] <= sel_wr;
        wr_ptr          <= wr_ptr + 1'b1;
        rr_ptr          <= ~sel_wr;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push) begin
        lock <= 1'b0;
      end else if (tcdm_req_o) begin
        lock       <= 1'b1;
        lock_owner <= sel_wr;
      end else if (lock_dropped) begin
        lock <= 1'b0;
      end
    end
  end

`ifdef AXI2MEM_TCDM_ARB_ERR_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)                                               err_o <= 1'b0;
    else if ((tcdm_r_valid_i && count == '0) || lock_dropped) err_o <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_axi2mem_tcdm_rdwr_arb.sv
// Directed bench for axi2mem_tcdm_rdwr_arb: inputs change 1ns after the rising
// edge, outputs are checked mid-cycle against hand-computed values.
module tb_axi2mem_tcdm_rdwr_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req, rd_we, wr_req, wr_we;
  logic [31:0] rd_add, rd_wdata, wr_add, wr_wdata;
  logic [3:0]  rd_be, wr_be;
  logic        rd_gnt, rd_r_valid, wr_gnt, wr_r_valid;
  logic [31:0] rd_r_rdata, wr_r_rdata;
  logic        tcdm_req, tcdm_we, tcdm_gnt, tcdm_r_valid;
  logic [31:0] tcdm_add, tcdm_wdata, tcdm_r_rdata;
  logic [3:0]  tcdm_be;
`ifdef AXI2MEM_TCDM_ARB_ERR_EN
  logic        err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi2mem_tcdm_rdwr_arb #(.MAX_OUTSTANDING(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .rd_req_i(rd_req), .rd_add_i(rd_add), .rd_we_i(rd_we), .rd_wdata_i(rd_wdata),
    .rd_be_i(rd_be), .rd_gnt_o(rd_gnt), .rd_r_rdata_o(rd_r_rdata), .rd_r_valid_o(rd_r_valid),
    .wr_req_i(wr_req), .wr_add_i(wr_add), .wr_we_i(wr_we), .wr_wdata_i(wr_wdata),
    .wr_be_i(wr_be), .wr_gnt_o(wr_gnt), .wr_r_rdata_o(wr_r_rdata), .wr_r_valid_o(wr_r_valid),
    .tcdm_req_o(tcdm_req), .tcdm_add_o(tcdm_add), .tcdm_we_o(tcdm_we),
    .tcdm_wdata_o(tcdm_wdata), .tcdm_be_o(tcdm_be), .tcdm_gnt_i(tcdm_gnt),
    .tcdm_r_rdata_i(tcdm_r_rdata), .tcdm_r_valid_i(tcdm_r_valid)
`ifdef AXI2MEM_TCDM_ARB_ERR_EN
    , .err_o(err)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge, where inputs are changed.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle, then sample mid-cycle.
  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    rd_req = 1'b0; wr_req = 1'b0; tcdm_gnt = 1'b0; tcdm_r_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rd_add = 32'h100; rd_we = 1'b1; rd_wdata = 32'h1111_1111; rd_be = 4'hF;
    wr_add = 32'h200; wr_we = 1'b0; wr_wdata = 32'h2222_2222; wr_be = 4'h3;
    tcdm_r_rdata = 32'hA5A5_A5A5;
    idle_inputs();
    step();
    do_reset();

    // Reset state: nothing requested, everything low.
    settle();
    check("rst_req",    tcdm_req,   0);
    check("rst_add",    tcdm_add,   0);
    check("rst_be",     tcdm_be,    0);
    check("rst_gnt",    {rd_gnt, wr_gnt}, 0);
    check("rst_rvalid", {rd_r_valid, wr_r_valid}, 0);
    check("rst_count",  dut.count,  0);

    // Read-only traffic with single-cycle response latency.
    step();
    rd_req = 1'b1; tcdm_gnt = 1'b1;
    settle();
    check("rd0_req",  tcdm_req, 1);
    check("rd0_add",  tcdm_add, 32'h100);
    check("rd0_we",   tcdm_we,  1);
    check("rd0_gnt",  {rd_gnt, wr_gnt}, 2'b10);
    step();
    tcdm_r_valid = 1'b1;
    settle();
    check("rd1_gnt",    rd_gnt,       1);
    check("rd1_rvalid", {rd_r_valid, wr_r_valid}, 2'b10);
    check("rd1_rdata",  rd_r_rdata,   32'hA5A5_A5A5);
    step();
    rd_req = 1'b0;
    settle();
    check("rd2_rvalid", {rd_r_valid, wr_r_valid}, 2'b10);
    check("rd2_req",    tcdm_req, 0);
    step();
    tcdm_r_valid = 1'b0;
    settle();
    check("rd3_count", dut.count, 0);

    // Both channels requesting: grants alternate RD,WR,... and responses follow.
    do_reset();
    rd_req = 1'b1; wr_req = 1'b1; tcdm_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tcdm_r_valid = (i != 0);
      settle();
      check("rr_gnt", {rd_gnt, wr_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
      check("rr_add", tcdm_add, (i % 2 == 0) ? 32'h100 : 32'h200);
      check("rr_rsp", {rd_r_valid, wr_r_valid},
            (i == 0) ? 2'b00 : (((i - 1) % 2 == 0) ? 2'b10 : 2'b01));
      step();
    end
    rd_req = 1'b0; wr_req = 1'b0;
    settle();
    check("rr_last_rsp", {rd_r_valid, wr_r_valid}, 2'b01);
    check("rr_last_rdata", wr_r_rdata, 32'hA5A5_A5A5);

    // Lock-on-stall: rr_ptr points at WR, TCDM stalls WR for three cycles.
    do_reset();
    rd_req = 1'b1; tcdm_gnt = 1'b1;
    step();
    wr_req = 1'b1; tcdm_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("lock_req", tcdm_req, 1);
      check("lock_add", tcdm_add, 32'h200);
      check("lock_gnt", {rd_gnt, wr_gnt}, 2'b00);
      step();
    end
    tcdm_gnt = 1'b1;
    settle();
    check("lock_wr_add", tcdm_add, 32'h200);
    check("lock_wr_gnt", {rd_gnt, wr_gnt}, 2'b01);
    step();
    tcdm_r_valid = 1'b1;
    settle();
    check("lock_rd_gnt", {rd_gnt, wr_gnt}, 2'b10);
    check("lock_rd_rsp", {rd_r_valid, wr_r_valid}, 2'b10);
    check("lock_count",  dut.count, 2);

    // Locked owner drops its request: the other channel is selected at once.
    do_reset();
    wr_req = 1'b1;
    step();
    wr_req = 1'b0; rd_req = 1'b1;
    settle();
    check("drop_add", tcdm_add, 32'h100);
    check("drop_we",  tcdm_we,  1);
    step();
`ifdef AXI2MEM_TCDM_ARB_ERR_EN
    settle();
    check("drop_err", err, 1);
`endif

    // Full queue: two grants, then no request until a response frees a slot.
    do_reset();
    rd_req = 1'b1; tcdm_gnt = 1'b1;
    step();
    step();
    settle();
    check("full_req",   tcdm_req,  0);
    check("full_gnt",   rd_gnt,    0);
    check("full_count", dut.count, 2);
    step();
    tcdm_r_valid = 1'b1;
    settle();
    check("full_issue_req", tcdm_req, 1);
    check("full_issue_gnt", rd_gnt,   1);
    check("full_issue_rsp", rd_r_valid, 1);
    step();
    tcdm_r_valid = 1'b0; rd_req = 1'b0;
    settle();
    check("full_count_held", dut.count, 2);

    // Reset with two outstanding, then a stale response is dropped.
    do_reset();
    settle();
    check("midrst_count", dut.count,  0);
    check("midrst_rr",    dut.rr_ptr, 0);
`ifdef AXI2MEM_TCDM_ARB_ERR_EN
    check("midrst_err",   err, 0);
`endif
    step();
    tcdm_r_valid = 1'b1;
    settle();
    check("stale_rsp", {rd_r_valid, wr_r_valid}, 2'b00);
    step();
    tcdm_r_valid = 1'b0;
    settle();
    check("stale_count", dut.count, 0);
`ifdef AXI2MEM_TCDM_ARB_ERR_EN
    check("stale_err", err, 1);
    step();
    settle();
    check("stale_err_sticky", err, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
